memory_responder: RTL
=====================

Name: memory_responder

Overview:
- Byte-organised data memory that services address requests issued from the address register file's OutC/OutD path (PC/SP/AR).
- Accepts a request through a Req/Ack handshake and performs an 8-bit or little-endian 16-bit read or write.
- Inserts a configurable number of wait states and flags out-of-range accesses with Err.
- Sits between the address-generation datapath and the control unit's memory-cycle sequencing.

Parameters:
- MEM_DEPTH, 1024: number of bytes in the array; valid addresses are 0..MEM_DEPTH-1.
- WAIT_STATES, 1: idle cycles inserted before the first byte access (0..15).
- PROTECT_LIMIT, 16'h0100: addresses below this value are read-only. Used only with MEMRESP_WRITE_PROTECT_EN.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low reset.
- Req  input  1  request valid; held high until Ack is seen.
- Wr  input  1  1 = write, 0 = read.
- Wide  input  1  1 = 16-bit access (bytes A and A+1), 0 = 8-bit access.
- Address  input  16  byte address A (OutC/OutD value).
- WrData  input  16  write data; the byte access uses [7:0].
- RdData  output  16  read data; valid while Ack is high.
- Ack  output  1  one-cycle completion pulse.
- Err  output  1  error qualifier; valid while Ack is high.
- Busy  output  1  high while a request is in flight.

Behaviour:
- Reset (Reset=0 at a rising edge):
  - state goes to IDLE; RdData=16'h0000; Ack=0, Err=0, Busy=0.
  - Memory contents are not cleared.
- Reset mid-operation: the transaction is abandoned. A wide write interrupted after LO leaves byte A written and A+1 untouched.
- States: IDLE, WAIT, LO, HI, DONE. All outputs are registered.
- IDLE:
  - On an edge with Req=1, capture Address, Wr, Wide and WrData.
  - Compute the error condition: A+Wide > MEM_DEPTH-1 (17-bit compare, no wrap).
  - If error, go to DONE with Err pending.
  - Otherwise go to WAIT if WAIT_STATES>0, else go to LO.
- WAIT: a counter loads WAIT_STATES-1 on entry. Leave for LO on the edge where the counter reads 0.
- LO:
  - Read: RdData[7:0] <= mem[A], RdData[15:8] <= 8'h00.
  - Write: mem[A] <= WrData[7:0].
  - Next state is HI if Wide, else DONE.
- HI:
  - Read: RdData[15:8] <= mem[A+1].
  - Write: mem[A+1] <= WrData[15:8].
  - Next state is DONE.
- DONE: Ack=1 for exactly one cycle, then return to IDLE.
- Ack timing: Ack is high in the cycle following edge (1 + WAIT_STATES + Wide), counting the sampling edge as edge 0.
- Error completion:
  - Err requests reach DONE one edge after sampling, with Ack=1, Err=1 and RdData=0.
  - No memory write occurs.
- Busy is 1 in WAIT, LO, HI and DONE; 0 in IDLE.
- Handshake rules:
  - Req is ignored outside IDLE; Address, Wr, Wide and WrData changes after capture have no effect.
  - The earliest next sample is the edge ending the Ack cycle. A Req held high through Ack starts a back-to-back request with no gap cycle.
- RdData holds its last value between transactions. A write transaction leaves RdData unchanged.
- The address is unsigned. A+1 is computed at 17 bits, so 16'hFFFF with Wide always errors.

Optional Feature:
- Macro: MEMRESP_WRITE_PROTECT_EN.
- With the macro: a write whose start address A < PROTECT_LIMIT takes the error path. It completes one edge after sampling with Ack=1, Err=1, no bytes written. Reads are unaffected. A wide write with A = PROTECT_LIMIT-1 is also rejected, because A lies below the limit.
- Without the macro: all in-range addresses are writable and PROTECT_LIMIT is unused.

Test Plan:
- Reset check: hold Reset=0 for 2 cycles with Req=1 -> Ack=0, Busy=0, RdData=16'h0000. Release, preload mem[0x10]=8'hAB -> byte read of 0x0010 gives Ack in the cycle after edge 2 (WAIT_STATES=1), RdData=16'h00AB.
- Wide write then read: write 16'hBEEF to 0x0020 with Wide=1 -> Ack after edge 3, mem[0x20]=8'hEF, mem[0x21]=8'hBE. Wide read of 0x0020 -> RdData=16'hBEEF, Err=0.
- Boundary: wide read of 0x03FF (MEM_DEPTH=1024) -> Ack after edge 1, Err=1, RdData=0. Byte read of 0x03FF -> Err=0. Read of 16'hFFFF with Wide=1 -> Err=1.
- Back-to-back: hold Req=1 through Ack with Address changed to 0x0021 -> second transaction sampled on the edge ending Ack, no idle cycle. Busy stays 1 and RdData=16'h00BE.
- Mid-op reset: wide write 16'h1234 to 0x0040 after clearing mem[0x40] and mem[0x41] to 8'h00, assert Reset=0 in the HI cycle -> mem[0x40]=8'h34, mem[0x41]=8'h00 unchanged, Ack never asserts, Busy=0 next cycle.
- With MEMRESP_WRITE_PROTECT_EN: write 8'h55 to 0x0080 -> Ack+Err after edge 1, mem[0x80] unchanged. Write to 0x0100 succeeds. Without the macro, the 0x0080 write succeeds with Err=0.

Source files
------------

// File: rtl/memory_responder.sv
// Byte-organised data memory with Req/Ack handshake, 8/16-bit little-endian access and wait states.
// Optional write protection of the low address window is enabled by defining MEMRESP_WRITE_PROTECT_EN.
module memory_responder #(
  parameter int MEM_DEPTH     = 1024,
  parameter int WAIT_STATES   = 1,
  parameter int PROTECT_LIMIT = 16'h0100
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic        Wide,
  input  logic [15:0] Address,
  input  logic [15:0] WrData,
  output logic [15:0] RdData,
  output logic        Ack,
  output logic        Err,
  output logic        Busy,
  output logic [2:0]  dbg_state
);

  // Handshake: a request is sampled on an edge where Req=1 while the responder is in IDLE,
  // or in DONE during the Ack cycle (back-to-back); Ack pulses for exactly one cycle per request.
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, LO, HI, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   addr_hi;
  logic [15:0]     wdata_q;
  logic            wr_q;
  logic            wide_q;
  logic            err_pend;
  logic [3:0]      wait_cnt;
  logic [7:0]      mem [MEM_DEPTH];

  logic [16:0]     end_addr;
  logic            range_err;
  logic            prot_err;
  logic            req_err;

  // End address is formed at 17 bits so 16'hFFFF plus one cannot wrap into range.
  assign end_addr  = {1'b0, Address} + {16'b0, Wide};
  assign range_err = end_addr > 17'(MEM_DEPTH - 1);

`ifdef MEMRESP_WRITE_PROTECT_EN
  assign prot_err = Wr && (Address < 16'(PROTECT_LIMIT));
`else
  assign prot_err = 1'b0;
`endif

  assign req_err   = range_err || prot_err;
  assign addr_hi   = addr_q + AW'(1);
  assign dbg_state = state;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= IDLE;
      RdData   <= 16'h0000;
      Ack      <= 1'b0;
      Err      <= 1'b0;
      Busy     <= 1'b0;
      err_pend <= 1'b0;
    end else begin
      Ack <= 1'b0;
      Err <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (state == DONE && err_pend) begin
            Ack      <= 1'b1;
            Err      <= 1'b1;
            RdData   <= 16'h0000;
            err_pend <= 1'b0;
          end else if (Req) begin
            addr_q   <= Address[AW-1:0];
            wr_q     <= Wr;
            wide_q   <= Wide;
            wdata_q  <= WrData;
            wait_cnt <= 4'(WAIT_STATES - 1);
            err_pend <= req_err;
            Busy     <= 1'b1;
            if (req_err)              state <= DONE;
            else if (WAIT_STATES > 0) state <= WAIT;
            else                      state <= LO;
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= LO;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        LO: begin
          if (!wr_q) RdData <= {8'h00, mem[addr_q]};
          if (wide_q) begin
            state <= HI;
          end else begin
            state <= DONE;
            Ack   <= 1'b1;
          end
        end
        HI: begin
          if (!wr_q) RdData[15:8] <= mem[addr_hi];
          state <= DONE;
          Ack   <= 1'b1;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  // Memory is never cleared; a reset edge suppresses the byte write that would otherwise occur.
  always_ff @(posedge Clock) begin
    if (Reset && wr_q) begin
      if (state == LO)      mem[addr_q]  <= wdata_q[7:0];
      else if (state == HI) mem[addr_hi] <= wdata_q[15:8];
    end
  end

endmodule
